fetch_sequencer: RTL

- Owns the program counter and drives the instruction memory's byte address.
- Captures the 32-bit instruction word returned combinationally and buffers {pc, inst, fault} in a small in-order fetch queue.
- Hands queue entries to decode over a valid/ready handshake.
- Handles branch/jump redirects and trap/mret redirects by flushing the queue and restarting fetch.

---
 rtl/fetch_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, buffers {pc, inst, fault} in an
// in-order queue and hands entries to decode over valid/ready; flushes on redirect/trap.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          IMEM_BYTES  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);
    localparam int          AW      = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] DEPTH   = (AW+1)'(QUEUE_DEPTH);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    localparam logic [0:0] FETCH  = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]    state;
    logic [31:0]   pc;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic [31:0] q_pc    [QUEUE_DEPTH];
    logic [31:0] q_inst  [QUEUE_DEPTH];
    logic        q_fault [QUEUE_DEPTH];

    logic flush;
    logic has_data;
    logic deq;
    logic enq;
    logic pc_fault;

    assign flush    = trap_valid | redirect_valid;
    assign has_data = (count != '0);
    assign pc_fault = (pc[1:0] != 2'b00) || (pc > LAST_PC);

    assign out_valid = has_data & ~flush;
    assign deq       = out_valid & out_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign enq       = (state == FETCH) && !flush && ((count != DEPTH) || deq);

    assign imem_pc   = pc;
    assign out_pc    = has_data ? q_pc[rd_ptr]    : 32'h0;
    assign out_inst  = has_data ? q_inst[rd_ptr]  : 32'h0;
    assign out_fault = has_data ? q_fault[rd_ptr] : 1'b0;

    // Queue storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]    <= pc;
            q_inst[wr_ptr]  <= pc_fault ? 32'h0 : imem_inst;
            q_fault[wr_ptr] <= pc_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= FETCH;
        end else if (flush) begin
            pc     <= trap_valid ? trap_pc : redirect_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= FETCH;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (pc_fault) begin
                    state <= HALTED;
                end else begin
                    pc <= pc + 32'd4;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end
endmodule
